// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the baccarat match controller.
package round_ctrl_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    OVER   = 2'd2
  } rc_state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_DEALER = 2'b10;

  localparam int DEF_TARGET_WINS = 5;
  localparam int DEF_AUTO_PERIOD = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/round_controller.sv
// Match-level controller: merges key and auto-play steps into one-cycle
// enables, tallies game results and ends the match at the target win count.
module round_controller
  import round_ctrl_pkg::*;
#(
  parameter int TARGET_WINS = DEF_TARGET_WINS,
  parameter int AUTO_PERIOD = DEF_AUTO_PERIOD,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             step_req,
  input  logic             auto_mode,
  input  logic             clear_match,
  input  logic             player_win_light,
  input  logic             dealer_win_light,
  output logic             step_en,
  output logic [CNT_W-1:0] round_count,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic             match_over,
  output logic [1:0]       match_winner,
  output rc_state_t        fsm_state
);

  localparam logic [7:0]     PHASE_LAST = 8'(AUTO_PERIOD - 1);
  // A win ends the match when the tally before this result is one short.
  localparam logic [CNT_W:0] TARGET_M1  = (CNT_W + 1)'(TARGET_WINS - 1);

  rc_state_t  state, state_next;
  logic       step_prev, light_prev;
  logic [7:0] phase;
  logic       step_edge, wrap, step_take;
  logic       result_evt, p_only, d_only, both_on;
  logic       p_hit, d_hit;

  always_comb begin
    step_edge  = step_req & ~step_prev;
    wrap       = (state == AUTO) && (phase == PHASE_LAST);
    step_take  = (step_edge | wrap) && (state != OVER) && !clear_match;

    result_evt = (player_win_light | dealer_win_light) & ~light_prev & ~clear_match;
    p_only     = result_evt & player_win_light & ~dealer_win_light;
    d_only     = result_evt & dealer_win_light & ~player_win_light;
    both_on    = result_evt & player_win_light & dealer_win_light;

    p_hit      = p_only && (state != OVER) && ({1'b0, player_wins} == TARGET_M1);
    d_hit      = d_only && (state != OVER) && ({1'b0, dealer_wins} == TARGET_M1);

    state_next = state;
    case (state)
      MANUAL: begin
        if (p_hit || d_hit) state_next = OVER;
        else if (auto_mode) state_next = AUTO;
      end
      AUTO: begin
        if (p_hit || d_hit)  state_next = OVER;
        else if (!auto_mode) state_next = MANUAL;
      end
      OVER: begin
        if (clear_match) state_next = MANUAL;
      end
      default: state_next = MANUAL;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state        <= MANUAL;
      step_prev    <= 1'b0;
      light_prev   <= 1'b0;
      phase        <= '0;
      step_en      <= 1'b0;
      match_winner <= WIN_NONE;
    end else begin
      state      <= state_next;
      // Edge history keeps sampling in OVER so a held key cannot fire on restart.
      step_prev  <= step_req;
      light_prev <= player_win_light | dealer_win_light;
      step_en    <= step_take;

      if (clear_match || (state != AUTO) || wrap) phase <= '0;
      else                                        phase <= phase + 8'd1;

      if (clear_match) match_winner <= WIN_NONE;
      else if (p_hit)  match_winner <= WIN_PLAYER;
      else if (d_hit)  match_winner <= WIN_DEALER;
    end
  end

  assign match_over = (state == OVER);
  assign fsm_state  = state;

  sat_counter #(.W(CNT_W)) u_rounds (
    .clk(slow_clock), .rst_n(resetb), .clear(clear_match), .inc(result_evt), .count(round_count)
  );
  sat_counter #(.W(CNT_W)) u_player (
    .clk(slow_clock), .rst_n(resetb), .clear(clear_match), .inc(p_only), .count(player_wins)
  );
  sat_counter #(.W(CNT_W)) u_dealer (
    .clk(slow_clock), .rst_n(resetb), .clear(clear_match), .inc(d_only), .count(dealer_wins)
  );
  sat_counter #(.W(CNT_W)) u_ties (
    .clk(slow_clock), .rst_n(resetb), .clear(clear_match), .inc(both_on), .count(ties)
  );

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with TARGET_WINS=2, AUTO_PERIOD=4, CNT_W=2.
module tb_round_controller;
  import round_ctrl_pkg::*;

  localparam int CNT_W = 2;

  logic             slow_clock;
  logic             resetb;
  logic             step_req;
  logic             auto_mode;
  logic             clear_match;
  logic             player_win_light;
  logic             dealer_win_light;
  logic             step_en;
  logic [CNT_W-1:0] round_count;
  logic [CNT_W-1:0] player_wins;
  logic [CNT_W-1:0] dealer_wins;
  logic [CNT_W-1:0] ties;
  logic             match_over;
  logic [1:0]       match_winner;
  rc_state_t        fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;

  round_controller #(
    .TARGET_WINS(2),
    .AUTO_PERIOD(4),
    .CNT_W(CNT_W)
  ) dut (
    .slow_clock(slow_clock),
    .resetb(resetb),
    .step_req(step_req),
    .auto_mode(auto_mode),
    .clear_match(clear_match),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light),
    .step_en(step_en),
    .round_count(round_count),
    .player_wins(player_wins),
    .dealer_wins(dealer_wins),
    .ties(ties),
    .match_over(match_over),
    .match_winner(match_winner),
    .fsm_state(fsm_state)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tallies(input string tag, input int r, input int p, input int d, input int t);
    chk({tag, ".rounds"}, 32'(round_count), 32'(r));
    chk({tag, ".player"}, 32'(player_wins), 32'(p));
    chk({tag, ".dealer"}, 32'(dealer_wins), 32'(d));
    chk({tag, ".ties"},   32'(ties),        32'(t));
  endtask

  initial begin
    resetb           = 1'b0;
    step_req         = 1'b0;
    auto_mode        = 1'b0;
    clear_match      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;

    // Reset values
    #12;
    chk("reset.step_en", 32'(step_en), 32'd0);
    chk_tallies("reset", 0, 0, 0, 0);
    chk("reset.match_over", 32'(match_over), 32'd0);
    chk("reset.winner", 32'(match_winner), 32'(WIN_NONE));
    chk("reset.state", 32'(fsm_state), 32'(MANUAL));
    resetb = 1'b1;
    tick();

    // Held key gives one pulse, the cycle after the first high sample
    step_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("key_hold.step_en[%0d]", i), 32'(step_en), 32'(i == 0));
    end
    step_req = 1'b0;
    tick();

    // Auto mode: pulses 4 cycles after entry then every 4; coincident key edge merges
    auto_mode = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 1) chk("auto.state", 32'(fsm_state), 32'(AUTO));
      chk($sformatf("auto.step_en[%0d]", i), 32'(step_en),
          32'((i >= 5) && (((i - 5) % 4) == 0)));
      if (i == 16) step_req = 1'b1;
    end
    auto_mode = 1'b0;
    step_req  = 1'b0;
    tick();
    chk("auto_off.state", 32'(fsm_state), 32'(MANUAL));
    chk("auto_off.step_en", 32'(step_en), 32'd0);
    tick();

    // Light patterns: each result counted once
    player_win_light = 1'b1;
    tick();
    chk_tallies("player_1st", 1, 1, 0, 0);
    tick();
    tick();
    chk_tallies("player_held", 1, 1, 0, 0);
    player_win_light = 1'b0;
    tick();
    player_win_light = 1'b1;
    dealer_win_light = 1'b1;
    tick();
    tick();
    chk_tallies("tie", 2, 1, 0, 1);
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    tick();
    dealer_win_light = 1'b1;
    tick();
    chk_tallies("dealer", 3, 1, 1, 1);
    chk("dealer.match_over", 32'(match_over), 32'd0);
    dealer_win_light = 1'b0;
    tick();

    // Mid-match clear zeroes tallies and keeps MANUAL
    clear_match = 1'b1;
    tick();
    chk_tallies("mid_clear", 0, 0, 0, 0);
    chk("mid_clear.state", 32'(fsm_state), 32'(MANUAL));
    clear_match = 1'b0;

    // Player reaches target of 2
    player_win_light = 1'b1;
    tick();
    player_win_light = 1'b0;
    tick();
    chk("target.one_win.match_over", 32'(match_over), 32'd0);
    player_win_light = 1'b1;
    tick();
    chk("target.player", 32'(player_wins), 32'd2);
    chk("target.match_over", 32'(match_over), 32'd1);
    chk("target.winner", 32'(match_winner), 32'(WIN_PLAYER));
    chk("target.state", 32'(fsm_state), 32'(OVER));
    player_win_light = 1'b0;
    step_req = 1'b1;
    tick();
    chk("over.key_edge.step_en", 32'(step_en), 32'd0);
    tick();
    chk("over.key_held.step_en", 32'(step_en), 32'd0);

    // clear_match while key still held: back to MANUAL, no step until re-press
    clear_match = 1'b1;
    tick();
    chk_tallies("over_clear", 0, 0, 0, 0);
    chk("over_clear.state", 32'(fsm_state), 32'(MANUAL));
    chk("over_clear.match_over", 32'(match_over), 32'd0);
    chk("over_clear.winner", 32'(match_winner), 32'(WIN_NONE));
    chk("over_clear.step_en", 32'(step_en), 32'd0);
    clear_match = 1'b0;
    tick();
    chk("held_after_clear.step_en0", 32'(step_en), 32'd0);
    tick();
    chk("held_after_clear.step_en1", 32'(step_en), 32'd0);
    step_req = 1'b0;
    tick();
    step_req = 1'b1;
    tick();
    chk("repress.step_en", 32'(step_en), 32'd1);
    step_req = 1'b0;
    tick();
    chk("repress.step_en_low", 32'(step_en), 32'd0);

    // Five ties saturate the 2-bit counters at 3
    for (int i = 0; i < 5; i++) begin
      player_win_light = 1'b1;
      dealer_win_light = 1'b1;
      tick();
      player_win_light = 1'b0;
      dealer_win_light = 1'b0;
      tick();
    end
    chk_tallies("saturate", 3, 0, 0, 3);

    // Reset mid-pulse clears everything immediately
    step_req = 1'b1;
    tick();
    chk("pre_reset.step_en", 32'(step_en), 32'd1);
    resetb = 1'b0;
    #1;
    chk("mid_reset.step_en", 32'(step_en), 32'd0);
    chk_tallies("mid_reset", 0, 0, 0, 0);
    chk("mid_reset.state", 32'(fsm_state), 32'(MANUAL));

    // Light still high at reset release is counted exactly once
    step_req         = 1'b0;
    player_win_light = 1'b1;
    #2;
    resetb = 1'b1;
    tick();
    chk_tallies("post_reset_light", 1, 1, 0, 0);
    tick();
    chk_tallies("post_reset_light_held", 1, 1, 0, 0);
    player_win_light = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/round_controller.md
# round_controller

Match-level controller for the baccarat game. It converts a synchronized "next" key, or an internal auto-play timer, into single-cycle step pulses that advance the game state machine one state per pulse. It watches the game's win lights and keeps saturating tallies of rounds, player wins, dealer wins and ties. When either side reaches a target win count it declares the match over and freezes stepping until the match is cleared.

## Interface
- `TARGET_WINS`, default 5: win count that ends the match; legal range 1..255.
- `AUTO_PERIOD`, default 4: cycles between auto-play step pulses; legal range 2..255.
- `CNT_W`, default 8: width of every tally counter.
- `slow_clock` in 1: single clock; all state updates on its rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `step_req` in 1: manual step key, already synchronized to `slow_clock`, active-high level.
- `auto_mode` in 1: level; 1 selects periodic auto-stepping.
- `clear_match` in 1: level; restarts the match from the OVER state, or zeroes the tallies mid-match.
- `player_win_light` in 1: game output.
- `dealer_win_light` in 1: game output. Both lights high means a tie.
- `step_en` out 1: one-cycle pulse; the game uses it as its clock enable.
- `round_count` out CNT_W: completed rounds.
- `player_wins` out CNT_W: rounds won by the player.
- `dealer_wins` out CNT_W: rounds won by the dealer.
- `ties` out CNT_W: tied rounds.
- `match_over` out 1: high while in the OVER state.
- `match_winner` out 2: 00 none, 01 player, 10 dealer; valid while `match_over` is high.

## Operation
- **States:**
  - MANUAL: reset state.
  - AUTO.
  - OVER.
- **Transitions:**
  - MANUAL→AUTO when `auto_mode`=1.
  - AUTO→MANUAL when `auto_mode`=0.
  - MANUAL or AUTO→OVER when a win tally reaches `TARGET_WINS`; this transition has priority over auto_mode changes.
  - OVER→MANUAL when `clear_match`=1.
- **Manual step:**
  - A rising edge of `step_req` (sampled 1, previous sample 0) requests one step.
  - Holding `step_req` high gives exactly one step.
  - Rising edges are accepted in both MANUAL and AUTO.
- **Auto step:**
  - In AUTO, the phase counter counts 0..`AUTO_PERIOD`-1 and a step is requested on the wrap to 0.
  - The phase counter is held at 0 in MANUAL and OVER.
- **Merging requests:** a manual edge and an auto wrap in the same cycle produce a single `step_en` pulse, never two.
- **OVER state:**
  - All step requests are discarded.
  - The edge detector keeps sampling, so a key still held when `clear_match` is applied does not produce a step.
- **Result detection:**
  - A result event is a rising edge of (`player_win_light` OR `dealer_win_light`). Each game result is tallied exactly once, however long the lights stay on.
  - On a result event, `round_count` increments, and so does exactly one of:
    - `player_wins`, when only the player light is high;
    - `dealer_wins`, when only the dealer light is high;
    - `ties`, when both lights are high.
- **Counter width:** all counters saturate at 2^CNT_W−1 and never wrap.
- **Match end:**
  - `match_winner` is set to the side whose tally reached `TARGET_WINS`.
  - A tie result never ends the match.
- **clear_match:**
  - Takes effect in any state.
  - Zeroes all four counters, the phase counter and `match_winner`.
  - Suppresses `step_en` for that cycle.
  - Any result event in the same cycle is dropped.

## Timing
- **Reset values** (`resetb`=0, asynchronous): state MANUAL; `step_en`=0; all counters 0; phase counter 0; `match_over`=0; `match_winner`=00; edge-detect history 0 for both `step_req` and the lights.
- **Step latency:** `step_en` is registered. If the request is sampled at edge N, `step_en` is high for the cycle after edge N and low again after edge N+1.
- **Auto cadence:** in steady AUTO, `step_en` pulses exactly once every `AUTO_PERIOD` cycles. The first pulse comes `AUTO_PERIOD` cycles after entering AUTO.
- **Tally latency:** a result sampled at edge N shows updated counters after edge N. `match_over` and `match_winner` update at that same edge.
- **Reset mid-round:** all state is lost immediately. A result whose lights are still high when `resetb` releases is counted once, because the light history resets to 0.

## Structure
- **Package `round_ctrl_pkg`:**
  - state enum `rc_state_t` {MANUAL, AUTO, OVER};
  - winner codes `WIN_NONE`, `WIN_PLAYER`, `WIN_DEALER`;
  - default parameter constants.
- **Sub-module `sat_counter` #(W):**
  - ports: clk, async active-low reset, sync clear, increment enable, count output;
  - saturates at all-ones;
  - instantiated four times, once per tally.

## Test plan
- **Reset, then single key press:** hold `step_req` high for 5 cycles → exactly one `step_en` pulse, in the cycle after the first high sample.
- **Auto mode:** `auto_mode`=1 for 12 cycles with `AUTO_PERIOD`=4 → 3 pulses, spaced 4 cycles apart; a manual edge coinciding with a wrap still gives one pulse.
- **Light patterns:**
  - Player light high for 3 cycles → `player_wins`=1, `round_count`=1.
  - Then both lights high → `ties`=1.
  - Then dealer light only → `dealer_wins`=1, `round_count`=3.
- **Player reaches target:** with `TARGET_WINS`=2, drive two player results → `match_over`=1 and `match_winner`=01 after the second result; further key edges produce no `step_en`.
- **clear_match with held key:** in OVER, pulse `clear_match` while `step_req` is held high → counters all 0, state MANUAL, no `step_en` until the key is released and pressed again.
- **Saturation and reset:** with `CNT_W`=2, drive 5 tie results → `ties`=3 and `round_count`=3. Assert `resetb`=0 mid-pulse → all outputs 0 immediately.
